// File: rtl/interrupt_ctrl_if.sv
// CPU-facing bus of the interrupt controller: IF/IE register access plus the
// dispatch handshake. The CPU side uses 'master', the controller uses 'slave'.
interface interrupt_ctrl_if;
  logic [15:0] address_bus;
  logic [7:0]  data_bus_in;
  logic        mem_we;
  logic        IME;
  logic        cpu_int_ack;
  logic        reg_rd_hit;
  logic [7:0]  reg_rd_data;
  logic        int_pending;
  logic        int_req;
  logic [15:0] int_vector;
  logic [4:0]  int_clear;

  modport master (
    output address_bus, data_bus_in, mem_we, IME, cpu_int_ack,
    input  reg_rd_hit, reg_rd_data, int_pending, int_req, int_vector, int_clear
  );

  modport slave (
    input  address_bus, data_bus_in, mem_we, IME, cpu_int_ack,
    output reg_rd_hit, reg_rd_data, int_pending, int_req, int_vector, int_clear
  );
endinterface

// File: rtl/interrupt_ctrl.sv
// Five-source interrupt controller with IF/IE registers and an IDLE/REQUEST/DISPATCH
// handshake. Define INT_REQ_EDGE_EN to set IF bits on request rising edges only.
module interrupt_ctrl (
  input  logic             clk4_2,
  input  logic             reset_n,
  interrupt_ctrl_if.slave  cpu,
  input  logic             v_blank_int_req,
  input  logic             lcd_stat_int_req,
  input  logic             timer_int_req,
  input  logic             serial_int_req,
  input  logic             joypad_int_req
);
  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, REQUEST, DISPATCH} state_t;

  state_t      state_q;
  logic [4:0]  if_q, if_d;
  logic [7:0]  ie_q, ie_d;
  logic        req_q;
  logic [15:0] vector_q;
  logic [4:0]  clear_q;

  logic [4:0]  req_vec, set_vec;
  logic [4:0]  pend_q, pend_d, sel_now;
  logic        we_if, we_ie, ack_take;

  // One-hot of the lowest set bit, i.e. the highest-priority source.
  function automatic logic [4:0] pick(input logic [4:0] p);
    pick = p & (~p + 5'd1);
  endfunction

  function automatic logic [15:0] vec_of(input logic [4:0] onehot);
    case (onehot)
      5'b00001: vec_of = 16'h0040;
      5'b00010: vec_of = 16'h0048;
      5'b00100: vec_of = 16'h0050;
      5'b01000: vec_of = 16'h0058;
      5'b10000: vec_of = 16'h0060;
      default:  vec_of = 16'h0000;
    endcase
  endfunction

  assign req_vec = {joypad_int_req, serial_int_req, timer_int_req,
                    lcd_stat_int_req, v_blank_int_req};

`ifdef INT_REQ_EDGE_EN
  logic [4:0] req_prev_q;

  always_ff @(posedge clk4_2 or negedge reset_n) begin
    if (!reset_n) req_prev_q <= 5'b0;
    else          req_prev_q <= req_vec;
  end

  assign set_vec = req_vec & ~req_prev_q;
`else
  assign set_vec = req_vec;
`endif

  assign pend_q  = ie_q[4:0] & if_q;
  assign sel_now = pick(pend_q);

  // Write, then dispatch clear, then request set: the set always wins.
  always_comb begin
    we_if    = cpu.mem_we && (cpu.address_bus == ADDR_IF);
    we_ie    = cpu.mem_we && (cpu.address_bus == ADDR_IE);
    ack_take = (state_q == REQUEST) && cpu.cpu_int_ack;
    if_d = if_q;
    if (we_if)    if_d = cpu.data_bus_in[4:0];
    if (ack_take) if_d = if_d & ~sel_now;
    if_d = if_d | set_vec;
    ie_d = we_ie ? cpu.data_bus_in : ie_q;
    pend_d = ie_d[4:0] & if_d;
  end

  always_ff @(posedge clk4_2 or negedge reset_n) begin
    if (!reset_n) begin
      if_q <= 5'h00;
      ie_q <= 8'h00;
    end else begin
      if_q <= if_d;
      ie_q <= ie_d;
    end
  end

  // Outputs are registered from next-cycle pending so the vector in REQUEST
  // always matches the IF/IE contents visible in that same cycle.
  always_ff @(posedge clk4_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      vector_q <= 16'h0000;
      clear_q  <= 5'b0;
    end else begin
      req_q    <= 1'b0;
      vector_q <= 16'h0000;
      clear_q  <= 5'b0;
      case (state_q)
        IDLE: begin
          if (cpu.IME && (pend_d != 5'b0)) begin
            state_q  <= REQUEST;
            req_q    <= 1'b1;
            vector_q <= vec_of(pick(pend_d));
          end
        end
        REQUEST: begin
          if (cpu.cpu_int_ack) begin
            state_q  <= DISPATCH;
            vector_q <= vec_of(sel_now);
            clear_q  <= sel_now;
          end else if (!cpu.IME || (pend_d == 5'b0)) begin
            state_q <= IDLE;
          end else begin
            req_q    <= 1'b1;
            vector_q <= vec_of(pick(pend_d));
          end
        end
        DISPATCH: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  assign cpu.int_pending = |pend_q;
  assign cpu.int_req     = req_q;
  assign cpu.int_vector  = vector_q;
  assign cpu.int_clear   = clear_q;

  always_comb begin
    cpu.reg_rd_hit  = 1'b0;
    cpu.reg_rd_data = 8'h00;
    if (cpu.address_bus == ADDR_IF) begin
      cpu.reg_rd_hit  = 1'b1;
      cpu.reg_rd_data = {3'b111, if_q};
    end else if (cpu.address_bus == ADDR_IE) begin
      cpu.reg_rd_hit  = 1'b1;
      cpu.reg_rd_data = ie_q;
    end
  end
endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed testbench for interrupt_ctrl: register access, priority, dispatch
// handshake, reset abandonment and request set behaviour (level or edge).
module tb_interrupt_ctrl;
  logic clk4_2 = 1'b0;
  logic reset_n = 1'b0;
  logic v_blank_int_req = 1'b0;
  logic lcd_stat_int_req = 1'b0;
  logic timer_int_req = 1'b0;
  logic serial_int_req = 1'b0;
  logic joypad_int_req = 1'b0;

  int errors = 0;
  int checks = 0;

  interrupt_ctrl_if bus ();

  interrupt_ctrl dut (
    .clk4_2           (clk4_2),
    .reset_n          (reset_n),
    .cpu              (bus),
    .v_blank_int_req  (v_blank_int_req),
    .lcd_stat_int_req (lcd_stat_int_req),
    .timer_int_req    (timer_int_req),
    .serial_int_req   (serial_int_req),
    .joypad_int_req   (joypad_int_req)
  );

  always #5 clk4_2 = ~clk4_2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk4_2);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    bus.address_bus = a;
    bus.mem_we = 1'b0;
    #1;
    d = bus.reg_rd_data;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.address_bus = a;
    bus.data_bus_in = d;
    bus.mem_we = 1'b1;
    step();
    bus.mem_we = 1'b0;
    bus.address_bus = 16'h0000;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    #1;
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL reset_int_req: got %b expected 0", bus.int_req); end
    checks++; if (bus.int_vector !== 16'h0000) begin errors++; $display("FAIL reset_vector: got %h expected 0000", bus.int_vector); end
    checks++; if (bus.int_clear !== 5'b0) begin errors++; $display("FAIL reset_clear: got %b expected 00000", bus.int_clear); end
    checks++; if (bus.int_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", bus.int_pending); end
    step();
    reset_n = 1'b1;
    step();
    rd(16'hFF0F, d);
    checks++; if (d !== 8'hE0) begin errors++; $display("FAIL reset_read_if: got %h expected e0", d); end
    checks++; if (bus.reg_rd_hit !== 1'b1) begin errors++; $display("FAIL hit_if: got %b expected 1", bus.reg_rd_hit); end
    rd(16'hFFFF, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_read_ie: got %h expected 00", d); end
    rd(16'h1234, d);
    checks++; if (d !== 8'h00 || bus.reg_rd_hit !== 1'b0) begin errors++; $display("FAIL miss_read: got %h hit %b expected 00 hit 0", d, bus.reg_rd_hit); end
  endtask

  task automatic test_timer_dispatch();
    logic [7:0] d;
    wr(16'hFFFF, 8'h1F);
    rd(16'hFFFF, d);
    checks++; if (d !== 8'h1F) begin errors++; $display("FAIL ie_write: got %h expected 1f", d); end
    bus.IME = 1'b1;
    timer_int_req = 1'b1;
    step();
    timer_int_req = 1'b0;
    checks++; if (bus.int_req !== 1'b1 || bus.int_vector !== 16'h0050) begin errors++; $display("FAIL timer_req: got req %b vec %h expected 1 0050", bus.int_req, bus.int_vector); end
    bus.cpu_int_ack = 1'b1;
    step();
    bus.cpu_int_ack = 1'b0;
    checks++; if (bus.int_clear !== 5'b00100) begin errors++; $display("FAIL timer_clear: got %b expected 00100", bus.int_clear); end
    checks++; if (bus.int_req !== 1'b0 || bus.int_vector !== 16'h0050) begin errors++; $display("FAIL timer_dispatch: got req %b vec %h expected 0 0050", bus.int_req, bus.int_vector); end
    rd(16'hFF0F, d);
    checks++; if (d !== 8'hE0) begin errors++; $display("FAIL timer_if_cleared: got %h expected e0", d); end
    step();
    checks++; if (bus.int_clear !== 5'b0 || bus.int_vector !== 16'h0000 || bus.int_req !== 1'b0) begin errors++; $display("FAIL timer_idle: got clr %b vec %h req %b expected 0 0000 0", bus.int_clear, bus.int_vector, bus.int_req); end
    bus.IME = 1'b0;
    wr(16'hFFFF, 8'h00);
  endtask

  task automatic test_priority();
    bus.IME = 1'b0;
    wr(16'hFFFF, 8'h10);
    wr(16'hFF0F, 8'h18);
    bus.IME = 1'b1;
    step();
    checks++; if (bus.int_req !== 1'b1 || bus.int_vector !== 16'h0060) begin errors++; $display("FAIL prio_joypad: got req %b vec %h expected 1 0060", bus.int_req, bus.int_vector); end
    wr(16'hFFFF, 8'h18);
    checks++; if (bus.int_req !== 1'b1 || bus.int_vector !== 16'h0058) begin errors++; $display("FAIL prio_serial: got req %b vec %h expected 1 0058", bus.int_req, bus.int_vector); end
    bus.IME = 1'b0;
    step();
    checks++; if (bus.int_req !== 1'b0 || bus.int_vector !== 16'h0000) begin errors++; $display("FAIL prio_ime_drop: got req %b vec %h expected 0 0000", bus.int_req, bus.int_vector); end
    wr(16'hFF0F, 8'h00);
    wr(16'hFFFF, 8'h00);
  endtask

  task automatic test_ime_gate_and_ack_race();
    logic [7:0] d;
    bus.IME = 1'b0;
    wr(16'hFFFF, 8'h01);
    v_blank_int_req = 1'b1;
    step();
    v_blank_int_req = 1'b0;
    checks++; if (bus.int_pending !== 1'b1) begin errors++; $display("FAIL ime_pending: got %b expected 1", bus.int_pending); end
    step();
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL ime_gate: got %b expected 0", bus.int_req); end
    bus.IME = 1'b1;
    step();
    checks++; if (bus.int_req !== 1'b1 || bus.int_vector !== 16'h0040) begin errors++; $display("FAIL ime_raise: got req %b vec %h expected 1 0040", bus.int_req, bus.int_vector); end
    // IME falls in the same cycle as ack: ack still dispatches.
    bus.IME = 1'b0;
    bus.cpu_int_ack = 1'b1;
    step();
    bus.cpu_int_ack = 1'b0;
    checks++; if (bus.int_clear !== 5'b00001 || bus.int_vector !== 16'h0040 || bus.int_req !== 1'b0) begin errors++; $display("FAIL ack_race: got clr %b vec %h req %b expected 00001 0040 0", bus.int_clear, bus.int_vector, bus.int_req); end
    rd(16'hFF0F, d);
    checks++; if (d !== 8'hE0) begin errors++; $display("FAIL ack_race_if: got %h expected e0", d); end
    step();
    checks++; if (bus.int_vector !== 16'h0000 || bus.int_clear !== 5'b0) begin errors++; $display("FAIL ack_race_idle: got vec %h clr %b expected 0000 00000", bus.int_vector, bus.int_clear); end
    wr(16'hFFFF, 8'h00);
  endtask

  task automatic test_ignored_ack();
    logic [7:0] d;
    bus.IME = 1'b0;
    wr(16'hFFFF, 8'h0C);
    wr(16'hFF0F, 8'h0C);
    bus.cpu_int_ack = 1'b1;
    step();
    bus.cpu_int_ack = 1'b0;
    rd(16'hFF0F, d);
    checks++; if (d !== 8'hEC || bus.int_clear !== 5'b0) begin errors++; $display("FAIL idle_ack: got if %h clr %b expected ec 00000", d, bus.int_clear); end
    bus.IME = 1'b1;
    step();
    checks++; if (bus.int_vector !== 16'h0050) begin errors++; $display("FAIL two_pending_vec: got %h expected 0050", bus.int_vector); end
    bus.cpu_int_ack = 1'b1;
    step();
    checks++; if (bus.int_clear !== 5'b00100) begin errors++; $display("FAIL two_pending_clr: got %b expected 00100", bus.int_clear); end
    step();
    bus.cpu_int_ack = 1'b0;
    rd(16'hFF0F, d);
    checks++; if (d !== 8'hE8 || bus.int_clear !== 5'b0 || bus.int_req !== 1'b0) begin errors++; $display("FAIL dispatch_ack_ignored: got if %h clr %b req %b expected e8 00000 0", d, bus.int_clear, bus.int_req); end
    step();
    checks++; if (bus.int_req !== 1'b1 || bus.int_vector !== 16'h0058) begin errors++; $display("FAIL next_bit: got req %b vec %h expected 1 0058", bus.int_req, bus.int_vector); end
    bus.IME = 1'b0;
    step();
    wr(16'hFF0F, 8'h00);
    wr(16'hFFFF, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    bit seen;
    wr(16'hFFFF, 8'h04);
    bus.IME = 1'b1;
    timer_int_req = 1'b1;
    step();
    timer_int_req = 1'b0;
    checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL b2b_req: got %b expected 1", bus.int_req); end
    // Re-request lands in the ack cycle, so the set beats the clear.
    timer_int_req = 1'b1;
    bus.cpu_int_ack = 1'b1;
    step();
    timer_int_req = 1'b0;
    bus.cpu_int_ack = 1'b0;
    checks++; if (bus.int_clear !== 5'b00100 || bus.int_req !== 1'b0) begin errors++; $display("FAIL b2b_dispatch: got clr %b req %b expected 00100 0", bus.int_clear, bus.int_req); end
    rd(16'hFF0F, d);
    checks++; if (d !== 8'hE4) begin errors++; $display("FAIL b2b_if_kept: got %h expected e4", d); end
    seen = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      step();
      if (bus.int_req === 1'b1 && bus.int_vector === 16'h0050) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL b2b_reassert: got req %b vec %h expected 1 0050 within 2 cycles", bus.int_req, bus.int_vector); end
    bus.IME = 1'b0;
    step();
    wr(16'hFF0F, 8'h00);
    wr(16'hFFFF, 8'h00);
  endtask

  task automatic test_edge_level();
    logic [7:0] d;
    logic [7:0] exp_end;
`ifdef INT_REQ_EDGE_EN
    exp_end = 8'hE0;
`else
    exp_end = 8'hF0;
`endif
    bus.IME = 1'b0;
    joypad_int_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      if (c == 3) begin
        bus.address_bus = 16'hFF0F;
        bus.data_bus_in = 8'h00;
        bus.mem_we = 1'b1;
      end
      step();
      bus.mem_we = 1'b0;
      if (c == 1) begin
        rd(16'hFF0F, d);
        checks++; if (d !== 8'hF0) begin errors++; $display("FAIL joypad_first_set: got %h expected f0", d); end
      end
      if (c == 4) begin
        rd(16'hFF0F, d);
        checks++; if (d !== exp_end) begin errors++; $display("FAIL joypad_after_write: got %h expected %h", d, exp_end); end
      end
    end
    joypad_int_req = 1'b0;
    rd(16'hFF0F, d);
    checks++; if (d !== exp_end) begin errors++; $display("FAIL joypad_end: got %h expected %h", d, exp_end); end
    step();
    wr(16'hFF0F, 8'h00);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    wr(16'hFFFF, 8'h01);
    bus.IME = 1'b1;
    v_blank_int_req = 1'b1;
    step();
    v_blank_int_req = 1'b0;
    checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL mid_req_setup: got %b expected 1", bus.int_req); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.int_req !== 1'b0 || bus.int_vector !== 16'h0000 || bus.int_pending !== 1'b0) begin errors++; $display("FAIL reset_mid_request: got req %b vec %h pend %b expected 0 0000 0", bus.int_req, bus.int_vector, bus.int_pending); end
    step();
    reset_n = 1'b1;
    wr(16'hFFFF, 8'h02);
    lcd_stat_int_req = 1'b1;
    step();
    lcd_stat_int_req = 1'b0;
    bus.cpu_int_ack = 1'b1;
    step();
    bus.cpu_int_ack = 1'b0;
    checks++; if (bus.int_clear !== 5'b00010 || bus.int_vector !== 16'h0048) begin errors++; $display("FAIL mid_dispatch_setup: got clr %b vec %h expected 00010 0048", bus.int_clear, bus.int_vector); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.int_clear !== 5'b0 || bus.int_vector !== 16'h0000 || bus.int_req !== 1'b0) begin errors++; $display("FAIL reset_mid_dispatch: got clr %b vec %h req %b expected 00000 0000 0", bus.int_clear, bus.int_vector, bus.int_req); end
    rd(16'hFFFF, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_mid_ie: got %h expected 00", d); end
    step();
    reset_n = 1'b1;
    bus.IME = 1'b0;
    step();
  endtask

  initial begin
    bus.address_bus = 16'h0000;
    bus.data_bus_in = 8'h00;
    bus.mem_we = 1'b0;
    bus.IME = 1'b0;
    bus.cpu_int_ack = 1'b0;
    test_reset();
    test_timer_dispatch();
    test_priority();
    test_ime_gate_and_ack_race();
    test_ignored_ack();
    test_back_to_back();
    test_edge_level();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/interrupt_ctrl.md
INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk4_2 (all state on rising edge) and reset_n (async assert, active low).
REQ-002 Ports SHALL be:
- clk4_2  in  1  system clock
- reset_n  in  1  async active-low reset
- address_bus  in  16  CPU address
- data_bus_in  in  8  CPU write data
- mem_we  in  1  CPU write strobe
- IME  in  1  master enable from CPU
- v_blank_int_req, lcd_stat_int_req, timer_int_req, serial_int_req, joypad_int_req  in  1 each  peripheral requests
- cpu_int_ack  in  1  CPU accepts dispatch; 1-cycle pulse
- reg_rd_hit  out  1  address_bus is 0xFF0F or 0xFFFF
- reg_rd_data  out  8  IF/IE read data
- int_pending  out  1  (IE & IF[4:0]) != 0, independent of IME; HALT wake
- int_req  out  1  dispatch request to CPU
- int_vector  out  16  dispatch target
- int_clear  out  5  one-hot IF bit cleared this cycle

Function
REQ-003 IF SHALL be a 5-bit register at 0xFF0F; bit0 vblank, 1 lcd_stat, 2 timer, 3 serial, 4 joypad.
REQ-004 IE SHALL be an 8-bit register at 0xFFFF; only IE[4:0] gates interrupts.
REQ-005 Writes SHALL occur when mem_we=1 and address matches; IF takes data_bus_in[4:0], IE takes data_bus_in[7:0].
REQ-006 Reads SHALL be combinational: 0xFF0F -> {3'b111, IF}; 0xFFFF -> IE; otherwise reg_rd_data=8'h00, reg_rd_hit=0.
REQ-007 Request-set of an IF bit SHALL take priority over a same-cycle CPU write and over a same-cycle dispatch clear of that bit.
REQ-008 Priority SHALL be fixed: bit0 highest, bit4 lowest; vectors 0x0040, 0x0048, 0x0050, 0x0058, 0x0060.
REQ-009 FSM states SHALL be IDLE, REQUEST and DISPATCH.
REQ-010 IDLE -> REQUEST SHALL occur when IME=1 and int_pending=1.
REQ-011 In REQUEST, int_req SHALL be 1 and int_vector SHALL track the highest-priority pending bit every cycle.
REQ-012 REQUEST -> IDLE without dispatch SHALL occur when IME=0 or int_pending=0 and cpu_int_ack=0 in that cycle.
REQ-013 REQUEST -> DISPATCH SHALL occur on cpu_int_ack=1, which freezes the selected bit and vector.
REQ-014 DISPATCH SHALL last exactly one cycle and then return to IDLE.
REQ-015 In DISPATCH, the frozen IF bit SHALL be cleared, int_clear SHALL be one-hot for that bit, int_req SHALL be 0, and int_vector SHALL hold the frozen value.
REQ-016 Ack-to-clear latency SHALL be exactly 1 cycle.
REQ-017 cpu_int_ack in IDLE or DISPATCH SHALL be ignored.
REQ-018 If ack coincides with a pending set becoming 0 (the REQ-012 condition), ack SHALL win using the bit selected in that cycle.
REQ-019 If nothing is pending at ack, the vector SHALL be 0x0000 and no bit SHALL be cleared.
REQ-020 Outside REQUEST/DISPATCH: int_vector=16'h0000, int_clear=5'b0, int_req=0.

Reset
REQ-021 On reset_n=0, outputs and state SHALL immediately be: IF=5'h00, IE=8'h00, state IDLE, int_req=0, int_vector=16'h0000, int_clear=5'b0, int_pending=0, and any edge-detect history cleared.
REQ-022 Reset mid-REQUEST or mid-DISPATCH SHALL abandon the dispatch with no IF clear.

Configuration
REQ-023 Macro INT_REQ_EDGE_EN: when defined, an IF bit SHALL be set only on a 0->1 transition of its request input, with the previous value registered per input.
REQ-024 Without INT_REQ_EDGE_EN, an IF bit SHALL be set every cycle its request input is 1 (level-sensitive).

Verification
REQ-025 Reset, then read 0xFF0F and 0xFFFF -> reg_rd_data 8'hE0 and 8'h00.
REQ-026 IE=8'h1F, IME=1, timer_int_req pulsed 1 cycle -> int_req=1, int_vector=0x0050 the next cycle; ack -> int_clear=5'b00100 and IF=5'h00 one cycle later.
REQ-027 IF written 5'h18, IE=8'h10, IME=1 -> vector 0x0060; write IE=8'h18 while in REQUEST -> vector 0x0058 the next cycle.
REQ-028 IME=0, IE=8'h01, vblank request -> int_pending=1, int_req stays 0; raise IME -> int_req=1, vector 0x0040.
REQ-029 Ack in the same cycle the dispatched bit is re-requested -> IF bit remains 1 after DISPATCH, and int_req reasserts the cycle after.
REQ-030 With INT_REQ_EDGE_EN, joypad_int_req held high 10 cycles and IF cleared by write in cycle 3 -> IF[4] stays 0; without the macro, IF[4] is set again in cycle 4.
